// File: rtl/ramio_fifo.sv
// ramio_fifo: CPU data-port bridge to cache, buffered UART TX/RX and LED bank.
// RAM accesses are lane-formatted; the top four byte addresses are mapped I/O.
module ramio_fifo #(
    parameter int ADDRESS_BITWIDTH  = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int LED_COUNT         = 4,
    parameter int TX_DEPTH_BITWIDTH = 3,
    parameter int RX_DEPTH_BITWIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_enable,
    input  logic [1:0]                  i_write_type,
    input  logic [2:0]                  i_read_type,
    input  logic [ADDRESS_BITWIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0]       i_data_in,
    output logic [DATA_WIDTH-1:0]       o_data_out,
    output logic                        o_data_out_ready,
    output logic                        o_busy,
    output logic [LED_COUNT-1:0]        o_led,
    output logic                        o_ram_enable,
    output logic [ADDRESS_BITWIDTH-1:0] o_ram_address,
    output logic [3:0]                  o_ram_write_enable,
    output logic [31:0]                 o_ram_data_in,
    input  logic [31:0]                 i_ram_data_out,
    input  logic                        i_ram_data_out_ready,
    input  logic                        i_ram_busy,
    output logic [7:0]                  o_tx_data,
    output logic                        o_tx_go,
    input  logic                        i_tx_bsy,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_dr,
    output logic                        o_rx_go
);
    localparam int TD = TX_DEPTH_BITWIDTH;
    localparam int RD = RX_DEPTH_BITWIDTH;
    localparam logic [ADDRESS_BITWIDTH-1:0] ADDR_LEDS        = '1;
    localparam logic [ADDRESS_BITWIDTH-1:0] ADDR_UART_OUT    = ADDR_LEDS - 1'b1;
    localparam logic [ADDRESS_BITWIDTH-1:0] ADDR_UART_IN     = ADDR_LEDS - 2'd2;
    localparam logic [ADDRESS_BITWIDTH-1:0] ADDR_UART_STATUS = ADDR_LEDS - 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} tx_state_t;

    tx_state_t          r_tx_st;
    logic [7:0]         r_tx_mem [2**TD];
    logic [7:0]         r_rx_mem [2**RD];
    logic [TD:0]        r_tx_wp, r_tx_rp;
    logic [RD:0]        r_rx_wp, r_rx_rp;
    logic [7:0]         r_tx_data, r_tx_last;
    logic               r_tx_go, r_rx_go, r_ovr;
    logic [LED_COUNT-1:0] r_led;

    logic        w_is_led, w_is_out, w_is_in, w_is_stat, w_io, w_ram;
    logic [1:0]  w_off;
    logic [3:0]  w_we;
    logic [7:0]  w_rb, w_rx_head;
    logic [15:0] w_rh;
    logic        w_sx;
    logic [31:0] w_ram_rd, w_io_rd, w_status;
    logic        w_tx_empty, w_tx_full, w_rx_ne, w_rx_full, w_tx_idle;
    logic        w_tx_wr, w_tx_push, w_tx_pop, w_rx_pop, w_rx_acc, w_rx_push;
    logic        w_ovr_set, w_stat_clr, w_led_wr;

    assign w_is_led  = i_address == ADDR_LEDS;
    assign w_is_out  = i_address == ADDR_UART_OUT;
    assign w_is_in   = i_address == ADDR_UART_IN;
    assign w_is_stat = i_address == ADDR_UART_STATUS;
    assign w_io      = w_is_led | w_is_out | w_is_in | w_is_stat;
    assign w_ram     = i_enable & ~w_io;
    assign w_off     = i_address[1:0];

    assign w_we = i_write_type == 2'b11 ? 4'b1111 :
                  i_write_type == 2'b01 ? 4'b0001 << w_off :
                  i_write_type == 2'b10 && !w_off[0] ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b0000;
    assign o_ram_data_in = i_write_type == 2'b01 ? {24'b0, i_data_in[7:0]} << {w_off, 3'b000} :
                           i_write_type == 2'b10 ? (w_off[1] ? {i_data_in[15:0], 16'b0} : {16'b0, i_data_in[15:0]}) :
                           i_data_in;
    assign o_ram_write_enable = w_ram ? w_we : 4'b0000;
    assign o_ram_enable       = w_ram;
    assign o_ram_address      = {i_address[ADDRESS_BITWIDTH-1:2], 2'b00};

    assign w_rb = 8'(i_ram_data_out >> {w_off, 3'b000});
    assign w_rh = w_off[1] ? i_ram_data_out[31:16] : i_ram_data_out[15:0];
    assign w_sx = i_read_type[2];
    assign w_ram_rd = i_read_type[1:0] == 2'b01 ? {{24{w_sx & w_rb[7]}}, w_rb} :
                      i_read_type[1:0] == 2'b10 && !w_off[0] ? {{16{w_sx & w_rh[15]}}, w_rh} :
                      i_read_type[1:0] == 2'b11 ? i_ram_data_out : 32'b0;

    assign w_tx_empty = r_tx_wp == r_tx_rp;
    assign w_tx_full  = (r_tx_wp[TD] != r_tx_rp[TD]) && (r_tx_wp[TD-1:0] == r_tx_rp[TD-1:0]);
    assign w_rx_ne    = r_rx_wp != r_rx_rp;
    assign w_rx_full  = (r_rx_wp[RD] != r_rx_rp[RD]) && (r_rx_wp[RD-1:0] == r_rx_rp[RD-1:0]);
    assign w_tx_idle  = w_tx_empty && r_tx_st == S_IDLE;
    assign w_rx_head  = w_rx_ne ? r_rx_mem[r_rx_rp[RD-1:0]] : 8'h00;
    assign w_status   = {28'b0, r_ovr, w_tx_idle, w_tx_full, w_rx_ne};

    assign w_io_rd = w_is_stat ? w_status :
                     w_is_led ? 32'(r_led) :
                     i_read_type != 3'b001 ? 32'b0 :
                     w_is_in ? {24'b0, w_rx_head} : {24'b0, r_tx_last};

    assign o_data_out       = w_io ? w_io_rd : w_ram_rd;
    assign o_data_out_ready = w_io | i_ram_data_out_ready;
    assign o_busy           = w_io ? w_tx_wr & w_tx_full : i_ram_busy;

    // A stalled TX write retries every cycle and lands on the first edge with a free slot
    assign w_tx_wr    = i_enable & w_is_out & (i_write_type == 2'b01);
    assign w_tx_push  = w_tx_wr & ~w_tx_full;
    assign w_tx_pop   = r_tx_st == S_IDLE && !w_tx_empty && !i_tx_bsy;
    assign w_rx_pop   = i_enable & w_is_in & (i_read_type == 3'b001) & w_rx_ne;
    assign w_stat_clr = i_enable & w_is_stat & (i_read_type != 3'b000);
    assign w_led_wr   = i_enable & w_is_led & (i_write_type != 2'b00);
    assign w_rx_acc   = i_rx_dr & r_rx_go;
    assign w_rx_push  = w_rx_acc & (~w_rx_full | w_rx_pop);
    assign w_ovr_set  = w_rx_acc & ~w_rx_push;

    always_ff @(posedge clk) if (w_tx_push) r_tx_mem[r_tx_wp[TD-1:0]] <= i_data_in[7:0];
    always_ff @(posedge clk) if (w_rx_push) r_rx_mem[r_rx_wp[RD-1:0]] <= i_rx_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_tx_wp   <= '0;
            r_tx_rp   <= '0;
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_tx_last <= 8'h00;
            r_rx_go   <= 1'b1;
            r_ovr     <= 1'b0;
            r_led     <= '1;
        end else begin
            r_tx_wp   <= r_tx_wp + {{TD{1'b0}}, w_tx_push};
            r_tx_rp   <= r_tx_rp + {{TD{1'b0}}, w_tx_pop};
            r_rx_wp   <= r_rx_wp + {{RD{1'b0}}, w_rx_push};
            r_rx_rp   <= r_rx_rp + {{RD{1'b0}}, w_rx_pop};
            r_tx_last <= w_tx_push ? i_data_in[7:0] : r_tx_last;
            r_rx_go   <= ~w_rx_acc;
            r_ovr     <= w_ovr_set | (r_ovr & ~w_stat_clr);
            r_led     <= w_led_wr ? i_data_in[LED_COUNT-1:0] : r_led;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_tx_st   <= S_IDLE;
            r_tx_data <= 8'h00;
            r_tx_go   <= 1'b0;
        end else begin
            case (r_tx_st)
                S_IDLE: if (w_tx_pop) begin
                    r_tx_data <= r_tx_mem[r_tx_rp[TD-1:0]];
                    r_tx_go   <= 1'b1;
                    r_tx_st   <= S_START;
                end
                S_START: if (i_tx_bsy) r_tx_st <= S_RUN;
                S_RUN: if (!i_tx_bsy) begin
                    r_tx_go <= 1'b0;
                    r_tx_st <= S_IDLE;
                end
                default: r_tx_st <= S_IDLE;
            endcase
        end

    assign o_tx_data = r_tx_data;
    assign o_tx_go   = r_tx_go;
    assign o_rx_go   = r_rx_go;
    assign o_led     = r_led;
endmodule
